// File: rtl/alarm_pkg.sv
// Shared types and defaults for the two-sensor intrusion alarm.
package alarm_pkg;

    typedef enum logic [1:0] {
        QUIET = 2'b00,
        OCCUR = 2'b01,
        ALARM = 2'b10
    } alarm_state_t;

    localparam int unsigned PERSIST_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/alarm.sv
// Two-sensor intrusion alarm: occurrence flag on any sensor, sticky alarm light on
// both sensors together or one sensor persisting for PERSIST_CYCLES OCCUR cycles.
module alarm
    import alarm_pkg::*;
#(
    parameter int unsigned PERSIST_CYCLES = PERSIST_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = 4
) (
    input  logic clk,
    input  logic sens1,
    input  logic sens2,
    input  logic reset,
    output logic occurrence,
    output logic alarm_l
);

    localparam logic [CNT_W-1:0] PERSIST_LIM = CNT_W'(PERSIST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    alarm_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_sens, both_sens;

    assign any_sens  = sens1 | sens2;
    assign both_sens = sens1 & sens2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= QUIET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the number of OCCUR cycles seen so far, including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            QUIET: begin
                if (any_sens) begin
                    state_d = OCCUR;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            OCCUR: begin
                if (both_sens) begin
                    state_d = ALARM;
                end else if (any_sens) begin
                    if (cnt_q >= PERSIST_LIM) begin
                        state_d = ALARM;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = QUIET;
                    cnt_d   = '0;
                end
            end
            ALARM: begin
                state_d = ALARM;
            end
            default: begin
                state_d = QUIET;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        occurrence = 1'b0;
        alarm_l    = 1'b0;
        case (state_q)
            OCCUR: occurrence = 1'b1;
            ALARM: begin
                occurrence = 1'b1;
                alarm_l    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alarm.sv
// Directed self-checking bench for the alarm FSM with default PERSIST_CYCLES=4.
module tb_alarm;

    logic clk = 1'b0;
    logic sens1, sens2, reset;
    logic occurrence, alarm_l;
    int   compared   = 0;
    int   mismatched = 0;

    alarm dut (
        .clk        (clk),
        .sens1      (sens1),
        .sens2      (sens2),
        .reset      (reset),
        .occurrence (occurrence),
        .alarm_l    (alarm_l)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic s1, input logic s2);
        reset = r;
        sens1 = s1;
        sens2 = s2;
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step_chk(input string tag, input logic exp_occ, input logic exp_al);
        @(posedge clk);
        #1;
        compared++;
        assert (occurrence === exp_occ)
        else begin
            mismatched++;
            $error("FAIL %s occurrence got %b want %b", tag, occurrence, exp_occ);
        end
        compared++;
        assert (alarm_l === exp_al)
        else begin
            mismatched++;
            $error("FAIL %s alarm_l got %b want %b", tag, alarm_l, exp_al);
        end
    endtask

    initial begin
        // Reset held with both sensors active
        drive(1'b1, 1'b1, 1'b1);
        step_chk("rst_hold0", 1'b0, 1'b0);
        step_chk("rst_hold1", 1'b0, 1'b0);
        step_chk("rst_hold2", 1'b0, 1'b0);

        // Release with quiet sensors
        drive(1'b0, 1'b0, 1'b0);
        step_chk("quiet_idle", 1'b0, 1'b0);

        // Single-cycle blip on sens1
        drive(1'b0, 1'b1, 1'b0);
        step_chk("blip_occ", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        step_chk("blip_back", 1'b0, 1'b0);
        step_chk("blip_stay", 1'b0, 1'b0);

        // Both sensors from QUIET
        drive(1'b0, 1'b1, 1'b1);
        step_chk("both_e1", 1'b1, 1'b0);
        step_chk("both_e2", 1'b1, 1'b1);

        // Sticky alarm with sensors idle
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step_chk("sticky", 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        step_chk("sticky_rst", 1'b0, 1'b0);

        // Persistence on sens2: alarm on edge 5
        drive(1'b0, 1'b0, 1'b1);
        step_chk("pers_e1", 1'b1, 1'b0);
        step_chk("pers_e2", 1'b1, 1'b0);
        step_chk("pers_e3", 1'b1, 1'b0);
        step_chk("pers_e4", 1'b1, 1'b0);
        step_chk("pers_e5", 1'b1, 1'b1);
        step_chk("pers_hold", 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        step_chk("pers_rst", 1'b0, 1'b0);

        // Drop sens2 at cnt=2
        drive(1'b0, 1'b0, 1'b1);
        step_chk("drop_e1", 1'b1, 1'b0);
        step_chk("drop_e2", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        step_chk("drop_quiet", 1'b0, 1'b0);

        // Alternating single sensors still count as persistence
        drive(1'b0, 1'b1, 1'b0);
        step_chk("alt_e1", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        step_chk("alt_e2", 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step_chk("alt_e3", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        step_chk("alt_e4", 1'b1, 1'b0);
        step_chk("alt_e5", 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        step_chk("alt_rst", 1'b0, 1'b0);

        // Second sensor joining mid-OCCUR goes straight to ALARM
        drive(1'b0, 1'b1, 1'b0);
        step_chk("join_e1", 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        step_chk("join_e2", 1'b1, 1'b1);

        // Reset overrides ALARM even with sensors high, then release with sensor high
        drive(1'b1, 1'b1, 1'b0);
        step_chk("rst_act0", 1'b0, 1'b0);
        step_chk("rst_act1", 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step_chk("rel_active", 1'b1, 1'b0);

        // Release with idle sensors, then raise sens1 a cycle later
        drive(1'b1, 1'b0, 1'b0);
        step_chk("rst_again", 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        step_chk("rel_idle", 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step_chk("rel_rise", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
